// File: rtl/vec_stream_src.sv
// Vector stream source: reads `length` consecutive words from a latency-1 memory
// and streams them out with valid/ready, marking the final element with out_end.
module vec_stream_src #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 16,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_end
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = PTR_W + 2;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_end_q, rd_end_d;
   logic                  infl_q, infl_d;
   logic                  infl_end_q, infl_end_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        count_q, count_d;
   logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
   logic                  buf_end_q  [BUF_DEPTH];

   logic             push, pop, credit_ok;
   logic [OCC_W-1:0] occ;

   assign out_valid = (count_q != '0);
   assign out_data  = buf_data_q[rd_ptr_q];
   assign out_end   = buf_end_q[rd_ptr_q];
   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_rd_en = rd_en_q;
   assign mem_addr  = addr_q;

   // A read is outstanding from its strobe cycle until its data lands in the
   // buffer, so both pipeline stages count against the buffer credits.
   always_comb begin
      push      = infl_q;
      pop       = out_valid & out_ready;
      occ       = OCC_W'(count_q) + OCC_W'(infl_q) + OCC_W'(rd_en_q) - OCC_W'(pop);
      credit_ok = (occ < OCC_W'(BUF_DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      rd_cnt_d   = rd_cnt_q;
      rd_en_d    = 1'b0;
      addr_d     = addr_q;
      rd_end_d   = 1'b0;
      infl_d     = rd_en_q;
      infl_end_d = rd_end_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               busy_d = 1'b1;
               if (length != '0) begin
                  // The first read goes out straight from the accepting edge.
                  len_d    = length;
                  rd_cnt_d = LEN_WIDTH'(1);
                  rd_en_d  = 1'b1;
                  addr_d   = base_addr;
                  rd_end_d = (length == LEN_WIDTH'(1));
                  state_d  = READ;
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         READ: begin
            if (rd_cnt_q == len_q) begin
               state_d = DRAIN;
            end else if (credit_ok) begin
               rd_en_d  = 1'b1;
               addr_d   = addr_q + ADDR_WIDTH'(1);
               rd_end_d = (rd_cnt_q == len_q - LEN_WIDTH'(1));
               rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (pop && out_end) begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         rd_cnt_q   <= '0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         rd_end_q   <= 1'b0;
         infl_q     <= 1'b0;
         infl_end_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_data_q[i] <= '0;
            buf_end_q[i]  <= 1'b0;
         end
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_en_q    <= rd_en_d;
         addr_q     <= addr_d;
         rd_end_q   <= rd_end_d;
         infl_q     <= infl_d;
         infl_end_q <= infl_end_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         if (push) begin
            buf_data_q[wr_ptr_q] <= mem_rd_data;
            buf_end_q[wr_ptr_q]  <= infl_end_q;
         end
      end
   end

endmodule
